// File: rtl/ntt_job_sched.sv
// Two-requester job scheduler in front of the NTT controller.
// A job is a run of N polynomials in one direction. Requesters are served round-robin.
// The scheduler issues one ntt_start per polynomial and waits for ntt_write_done between
// starts. A per-polynomial watchdog aborts a job whose controller stops answering.
module ntt_job_sched #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TO_W    = 13
) (
    input  logic             clk,
    input  logic             aresetn,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_sel,
    input  logic [CNT_W-1:0] req0_count,
    output logic             req0_done,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_sel,
    input  logic [CNT_W-1:0] req1_count,
    output logic             req1_done,

    output logic             ntt_start,
    output logic             ntt_sel,
    input  logic             ntt_write_done,

    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] poly_idx,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StGap,
        StDone,
        StErr
    } state_t;

    localparam logic [TO_W-1:0]  WdLast  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntZero = '0;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_t           state_q;
    logic             rr_q;
    logic             grant_q;
    logic             sel_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] poly_idx_q;
    logic [TO_W-1:0]  wd_q;
    logic             ntt_start_q;
    logic             busy_q;
    logic             done0_q;
    logic             done1_q;
    logic             err_q;

    logic             grant_nxt;
    logic             accept;
    logic             accept_sel;
    logic [CNT_W-1:0] accept_cnt;

    // Arbitration and same-cycle ready; ready is forced low while reset is held so all
    // outputs read 0 during reset even though the FSM sits in IDLE.
    always_comb begin
        grant_nxt  = (req0_valid && req1_valid) ? rr_q : req1_valid;
        accept     = aresetn && (state_q == StIdle) && (req0_valid || req1_valid);
        accept_sel = grant_nxt ? req1_sel : req0_sel;
        accept_cnt = grant_nxt ? req1_count : req0_count;
        req0_ready = accept && !grant_nxt;
        req1_ready = accept && grant_nxt;
    end

    // Job FSM with registered outputs; the sticky error flag shares this block so that a
    // timeout and err_clr landing in the same cycle resolve with set winning.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            rr_q        <= 1'b0;
            grant_q     <= 1'b0;
            sel_q       <= 1'b0;
            remaining_q <= '0;
            poly_idx_q  <= '0;
            wd_q        <= '0;
            ntt_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ntt_start_q <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            if (err_clr) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        grant_q     <= grant_nxt;
                        sel_q       <= accept_sel;
                        remaining_q <= accept_cnt;
                        poly_idx_q  <= '0;
                        busy_q      <= 1'b1;
                        if (accept_cnt == CntZero) begin
                            // Empty job completes without touching the controller.
                            state_q <= StDone;
                            done0_q <= !grant_nxt;
                            done1_q <= grant_nxt;
                        end else begin
                            state_q     <= StStart;
                            ntt_start_q <= 1'b1;
                        end
                    end
                end

                StStart: begin
                    wd_q    <= '0;
                    state_q <= StWait;
                end

                StWait: begin
                    // write_done takes priority over an expiring watchdog.
                    if (ntt_write_done) begin
                        remaining_q <= remaining_q - CntOne;
                        if (remaining_q == CntOne) begin
                            state_q <= StDone;
                            done0_q <= !grant_q;
                            done1_q <= grant_q;
                        end else begin
                            poly_idx_q <= poly_idx_q + CntOne;
                            state_q    <= StGap;
                        end
                    end else if (wd_q == WdLast) begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                        done0_q <= !grant_q;
                        done1_q <= grant_q;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end

                StGap: begin
                    // Let the controller settle back to idle before the next start.
                    state_q     <= StStart;
                    ntt_start_q <= 1'b1;
                end

                StDone, StErr: begin
                    rr_q    <= !grant_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ntt_start = ntt_start_q;
    assign ntt_sel   = sel_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign poly_idx  = poly_idx_q;
    assign req0_done = done0_q;
    assign req1_done = done1_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ntt_job_sched.sv
// Directed bench for ntt_job_sched: arbitration table plus hand sequences for jobs,
// zero-count, contention, mid-job reset, watchdog timeout and its boundary.
module tb_ntt_job_sched;

    localparam int CNT_W = 4;

    logic             clk;
    logic             aresetn;
    logic             req0_valid, req1_valid;
    logic             req0_sel, req1_sel;
    logic [CNT_W-1:0] req0_count, req1_count;
    logic             ntt_write_done;
    logic             err_clr;

    // Outputs of the default-timeout instance.
    logic             req0_ready, req1_ready, req0_done, req1_done;
    logic             ntt_start, ntt_sel, busy, grant_id, err;
    logic [CNT_W-1:0] poly_idx;

    // Outputs of the short-timeout (16) instance.
    logic             t_req0_ready, t_req1_ready, t_req0_done, t_req1_done;
    logic             t_ntt_start, t_ntt_sel, t_busy, t_grant_id, t_err;
    logic [CNT_W-1:0] t_poly_idx;

    int total;
    int bad;

    ntt_job_sched #(.CNT_W(CNT_W), .TIMEOUT(4096), .TO_W(13)) dut (
        .clk(clk), .aresetn(aresetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_count(req0_count), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_count(req1_count), .req1_done(req1_done),
        .ntt_start(ntt_start), .ntt_sel(ntt_sel), .ntt_write_done(ntt_write_done),
        .busy(busy), .grant_id(grant_id), .poly_idx(poly_idx),
        .err(err), .err_clr(err_clr)
    );

    ntt_job_sched #(.CNT_W(CNT_W), .TIMEOUT(16), .TO_W(5)) dut_to (
        .clk(clk), .aresetn(aresetn),
        .req0_valid(req0_valid), .req0_ready(t_req0_ready), .req0_sel(req0_sel),
        .req0_count(req0_count), .req0_done(t_req0_done),
        .req1_valid(req1_valid), .req1_ready(t_req1_ready), .req1_sel(req1_sel),
        .req1_count(req1_count), .req1_done(t_req1_done),
        .ntt_start(t_ntt_start), .ntt_sel(t_ntt_sel), .ntt_write_done(ntt_write_done),
        .busy(t_busy), .grant_id(t_grant_id), .poly_idx(t_poly_idx),
        .err(t_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    typedef struct {
        int   phase;  // 0: rr points at 0, 1: rr points at 1
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } arb_vec_t;

    arb_vec_t arb_tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic run_arb(input int ph);
        for (int i = 0; i < 6; i++) begin
            if (arb_tbl[i].phase == ph) begin
                req0_valid = arb_tbl[i].v0;
                req1_valid = arb_tbl[i].v1;
                #1;
                check($sformatf("arb%0d_r0", i), req0_ready, arb_tbl[i].r0);
                check($sformatf("arb%0d_r1", i), req1_ready, arb_tbl[i].r1);
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                #1;
            end
        end
    endtask

    // Caller presents the request in an IDLE cycle; the job runs to completion with
    // write_done returned lat cycles after each start, plus a spurious write_done in
    // every GAP/DONE cycle.
    task automatic do_job(input int g, input logic s, input int n, input int lat,
                          input bit keep);
        int starts;
        #1;
        check("ready_win", g ? req1_ready : req0_ready, 1);
        check("ready_lose", g ? req0_ready : req1_ready, 0);
        tick();
        if (!keep) begin
            if (g == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
        end
        for (int p = 0; p < n; p++) begin
            check($sformatf("start_p%0d", p), ntt_start, 1);
            check($sformatf("sel_p%0d", p), ntt_sel, s);
            check($sformatf("idx_p%0d", p), poly_idx, p);
            check("grant", grant_id, g);
            check("ready_busy", {req0_ready, req1_ready}, 0);
            starts = 0;
            for (int c = 0; c < lat; c++) begin
                tick();
                if (ntt_start) starts++;
            end
            check("no_start_in_wait", starts, 0);
            ntt_write_done = 1'b1;
            tick();
            ntt_write_done = 1'b0;
            if (p < n - 1) begin
                check("gap_start", ntt_start, 0);
                check("gap_idx", poly_idx, p + 1);
                check("gap_done", {req0_done, req1_done}, 0);
                ntt_write_done = 1'b1;
                tick();
                ntt_write_done = 1'b0;
            end else begin
                check("done_pulse", {req1_done, req0_done}, (g == 0) ? 2'b01 : 2'b10);
                check("done_busy", busy, 1);
                check("done_sel", ntt_sel, s);
                check("done_idx", poly_idx, n - 1);
                ntt_write_done = 1'b1;
                tick();
                ntt_write_done = 1'b0;
                check("idle_busy", busy, 0);
                check("idle_done", {req0_done, req1_done}, 0);
                check("idle_start", ntt_start, 0);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        aresetn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_sel = 1'b0;   req1_sel = 1'b0;
        req0_count = '0;   req1_count = '0;
        ntt_write_done = 1'b0;
        err_clr = 1'b0;

        arb_tbl[0] = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
        arb_tbl[1] = '{0, 1'b1, 1'b0, 1'b1, 1'b0};
        arb_tbl[2] = '{0, 1'b0, 1'b1, 1'b0, 1'b1};
        arb_tbl[3] = '{0, 1'b1, 1'b1, 1'b1, 1'b0};
        arb_tbl[4] = '{1, 1'b1, 1'b1, 1'b0, 1'b1};
        arb_tbl[5] = '{1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state, with both requests asserted to show ready is held low.
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_start", ntt_start, 0);
        check("rst_sel", ntt_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_idx", poly_idx, 0);
        check("rst_err", err, 0);
        check("rst_done", {req0_done, req1_done}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        aresetn = 1'b1;
        tick();

        // Arbitration with rr at 0.
        run_arb(0);

        // Single job: 3 polys, INTT, write_done 20 cycles after each start.
        tick();
        req0_valid = 1'b1; req0_sel = 1'b1; req0_count = 4'd3;
        do_job(0, 1'b1, 3, 20, 1'b0);

        // Spurious write_done in IDLE.
        ntt_write_done = 1'b1;
        tick();
        ntt_write_done = 1'b0;
        tick();
        check("idle_wd_busy", busy, 0);
        check("idle_wd_start", ntt_start, 0);
        check("idle_wd_err", err, 0);

        // Arbitration with rr now at 1.
        run_arb(1);

        // Zero-count job on requester 1.
        tick();
        req1_valid = 1'b1; req1_count = 4'd0; req1_sel = 1'b1;
        #1;
        check("zero_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        check("zero_done", {req1_done, req0_done}, 2'b10);
        check("zero_busy1", busy, 1);
        check("zero_start1", ntt_start, 0);
        tick();
        check("zero_busy2", busy, 0);
        check("zero_done2", req1_done, 0);
        check("zero_start2", ntt_start, 0);

        // Contention from reset: grants alternate 0, 1, 0.
        aresetn = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_count = 4'd1; req1_count = 4'd1;
        req0_sel = 1'b0;   req1_sel = 1'b1;
        tick();
        tick();
        aresetn = 1'b1;
        do_job(0, 1'b0, 1, 3, 1'b1);
        do_job(1, 1'b1, 1, 3, 1'b1);
        do_job(0, 1'b0, 1, 3, 1'b0);
        req1_valid = 1'b0;

        // Reset in the middle of poly 1 of a 3-poly job.
        do_reset();
        req0_valid = 1'b1; req0_sel = 1'b1; req0_count = 4'd3;
        #1;
        check("mr_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        repeat (5) tick();
        ntt_write_done = 1'b1;
        tick();
        ntt_write_done = 1'b0;
        tick();
        check("mr_start2", ntt_start, 1);
        check("mr_idx2", poly_idx, 1);
        repeat (3) tick();
        #2;
        aresetn = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_idx", poly_idx, 0);
        check("mr_sel", ntt_sel, 0);
        check("mr_start", ntt_start, 0);
        check("mr_done", {req0_done, req1_done}, 0);
        tick();
        tick();
        check("mr_done_hold", {req0_done, req1_done}, 0);
        aresetn = 1'b1;
        req0_valid = 1'b1; req0_sel = 1'b0; req0_count = 4'd2;
        do_job(0, 1'b0, 2, 4, 1'b0);

        // Timeout on the TIMEOUT=16 instance, with err_clr colliding with the set.
        do_reset();
        req0_valid = 1'b1; req0_sel = 1'b0; req0_count = 4'd2;
        #1;
        check("to_ready", t_req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("to_start", t_ntt_start, 1);
        repeat (16) tick();
        check("to_err_pre", t_err, 0);
        check("to_done_pre", t_req0_done, 0);
        check("to_busy_pre", t_busy, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err", t_err, 1);
        check("to_done", {t_req1_done, t_req0_done}, 2'b01);
        tick();
        check("to_idle_busy", t_busy, 0);
        check("to_err_sticky", t_err, 1);
        check("to_done_off", t_req0_done, 0);
        ntt_write_done = 1'b1;
        tick();
        ntt_write_done = 1'b0;
        check("to_late_wd_err", t_err, 1);
        check("to_late_wd_busy", t_busy, 0);
        check("to_late_wd_start", t_ntt_start, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_clr", t_err, 0);

        // write_done on the last watchdog cycle keeps the job alive.
        req0_valid = 1'b1; req0_sel = 1'b1; req0_count = 4'd2;
        #1;
        check("bd_ready", t_req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("bd_start", t_ntt_start, 1);
        repeat (16) tick();
        ntt_write_done = 1'b1;
        tick();
        ntt_write_done = 1'b0;
        check("bd_err", t_err, 0);
        check("bd_idx", t_poly_idx, 1);
        check("bd_busy", t_busy, 1);
        check("bd_done", t_req0_done, 0);
        tick();
        check("bd_start2", t_ntt_start, 1);
        check("bd_sel", t_ntt_sel, 1);
        tick();
        ntt_write_done = 1'b1;
        tick();
        ntt_write_done = 1'b0;
        check("bd_done2", t_req0_done, 1);
        check("bd_err2", t_err, 0);
        tick();
        check("bd_idle", t_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_job_sched.md
Name: ntt_job_sched

Overview:
- Two-requester job scheduler in front of the NTT controller; owns its start/sel inputs.
- Each requester submits a job of N polynomials with a direction (NTT/INTT).
- Block arbitrates round-robin, then issues one start pulse per polynomial and waits for write_done between them.
- Signals per-requester completion and aborts on a watchdog timeout.

Parameters:
- CNT_W, 4, width of polynomial count per job (max 2^CNT_W-1 polys).
- TIMEOUT, 4096, max cycles from ntt_start to ntt_write_done before error.
- TO_W, 13, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 job request.
- req0_ready  out  1  job 0 accepted this cycle.
- req0_sel  in  1  direction for job 0 (0 NTT, 1 INTT), sampled on accept.
- req0_count  in  CNT_W  polynomials in job 0, sampled on accept.
- req0_done  out  1  one-cycle pulse, job 0 finished.
- req1_valid, req1_ready, req1_sel, req1_count, req1_done  —  same as requester 0, for requester 1.
- ntt_start  out  1  one-cycle start pulse to NTT controller.
- ntt_sel  out  1  direction to NTT controller, held for the whole job.
- ntt_write_done  in  1  NTT controller finished writing one polynomial.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester owning the current job.
- poly_idx  out  CNT_W  index of the polynomial in flight (0-based).
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset (async, aresetn low), all outputs 0:
  - ntt_start, ntt_sel, ready, done, busy, grant_id, poly_idx, err all 0.
  - rr pointer = 0 (requester 0 favoured); state IDLE.
- FSM states: IDLE, START, WAIT, GAP, DONE, ERR.
- IDLE:
  - Winner = the only valid requester, or rr pointer if both are valid.
  - reqX_ready asserted combinationally in the same cycle; the handshake completes on valid&ready.
  - Latch sel, count, grant_id; poly_idx = 0.
  - If count == 0 -> DONE (no ntt_start issued); else -> START.
  - ready is never high outside IDLE; the loser keeps valid asserted and is served after the current job.
- START:
  - ntt_start = 1 for exactly one cycle; ntt_sel = latched sel (registered, stable from START through DONE).
  - Clear watchdog; -> WAIT.
  - Accept-to-first-start latency: 1 cycle (accept at cycle T, ntt_start at T+1).
- WAIT:
  - Watchdog increments every cycle.
  - On ntt_write_done: remaining -= 1.
    - If remaining becomes 0 -> DONE.
    - Else poly_idx += 1 -> GAP.
  - If watchdog reaches TIMEOUT-1 without write_done -> ERR. If write_done arrives in that same cycle, write_done wins.
- GAP: one idle cycle so the NTT controller returns to its idle state; -> START. Next start follows write_done by exactly 2 cycles.
- DONE:
  - reqX_done pulse one cycle for grant_id.
  - rr pointer = ~grant_id; -> IDLE.
- ERR:
  - err set (sticky).
  - reqX_done pulses one cycle for grant_id, remaining polys abandoned.
  - rr pointer = ~grant_id; -> IDLE.
- ntt_write_done outside WAIT is ignored: no count change, no error.
- err_clr clears err in any state; if a timeout and err_clr coincide, set wins.
- poly_idx wraps only via reset to 0 on the next accept; it is never incremented past count-1.
- busy = (state != IDLE).
- Reset mid-job: all state clears immediately; no done pulse is issued. The NTT controller is expected to be reset by the same aresetn.

Test Plan:
- Single job: req0 count=3, sel=1, write_done returned 20 cycles after each start -> 3 ntt_start pulses, ntt_sel=1 throughout, poly_idx 0,1,2, starts 22 cycles apart, one req0_done after the third write_done.
- Contention: req0 and req1 both valid from reset, count=1 each -> req0 accepted first, req1 accepted in the cycle after req0_done returns to IDLE. Repeat both valid -> req1 now wins (rr alternates).
- Zero count: req1 count=0 -> req1_ready, then req1_done 1 cycle later, no ntt_start, busy high for exactly 1 cycle.
- Timeout: TIMEOUT=16, write_done withheld -> err=1 and req0_done at the 16th WAIT cycle, state IDLE. err_clr pulse -> err=0. Write_done arriving later is ignored.
- Boundary: write_done on the same cycle the watchdog hits TIMEOUT-1 -> no err, job continues. Spurious write_done in IDLE/GAP -> no effect.
- Reset mid-WAIT: aresetn low during job 2 of 3 -> all outputs 0 asynchronously, no done pulse. After release, a new job is accepted normally with poly_idx=0.
